// File: rtl/div8_seq.sv
`default_nettype none
// ============================================================================
// Module   : div8_seq
// Purpose  : Sequential 8-bit unsigned divider. Restoring shift-and-subtract,
//            one quotient bit per clock, MSB first, with a START/DONE
//            handshake. Divide-by-zero short-circuits to Q=FF, R=A, DZ=1.
// Ports    : CK     - system clock, rising edge
//            RSTn   - asynchronous active-low reset
//            START  - division request, sampled only while idle
//            A, B   - dividend / divisor, captured on the accepting edge
//            Q, R   - registered quotient / remainder
//            BUSY   - high while a division is in progress (RUN or FIN)
//            DONE   - one-cycle pulse, results valid from this cycle on
//            DZ     - divide-by-zero flag for the last result
// Revision : 1.0  initial release
// ============================================================================
module div8_seq (
  input  logic       CK,
  input  logic       RSTn,
  input  logic       START,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] Q,
  output logic [7:0] R,
  output logic       BUSY,
  output logic       DONE,
  output logic       DZ
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_FIN  = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_stateNext;

  logic [7:0] r_quoShift;   // dividend shifting out, quotient shifting in
  logic [7:0] r_divisor;
  logic [7:0] r_partRem;    // always < divisor, so 8 bits suffice
  logic [2:0] r_iterCnt;

  logic [8:0] w_trial;
  logic       w_fits;
  logic [7:0] w_remNext;
  logic [7:0] w_quoNext;

  // One restoring step. When the trial value fits, T-DV < 256, so the low
  // 8 bits of the modular difference are exact.
  always_comb begin
    w_trial   = {r_partRem, r_quoShift[7]};
    w_fits    = (w_trial >= {1'b0, r_divisor});
    w_remNext = w_fits ? (w_trial[7:0] - r_divisor) : w_trial[7:0];
    w_quoNext = {r_quoShift[6:0], w_fits};
  end

  // State register
  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      c_IDLE: begin
        if (START) begin
          w_stateNext = (B == 8'd0) ? c_FIN : c_RUN;
        end
      end
      c_RUN: begin
        if (r_iterCnt == 3'd7) begin
          w_stateNext = c_FIN;
        end
      end
      c_FIN:   w_stateNext = c_IDLE;
      default: w_stateNext = c_IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    BUSY = (r_state != c_IDLE);
    DONE = (r_state == c_FIN);
  end

  // Datapath and result registers. Results are written only on the edge
  // that enters FIN, so Q/R/DZ hold across a division in progress.
  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      r_quoShift <= 8'd0;
      r_divisor  <= 8'd0;
      r_partRem  <= 8'd0;
      r_iterCnt  <= 3'd0;
      Q          <= 8'd0;
      R          <= 8'd0;
      DZ         <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (START) begin
            if (B != 8'd0) begin
              r_quoShift <= A;
              r_divisor  <= B;
              r_partRem  <= 8'd0;
              r_iterCnt  <= 3'd0;
            end else begin
              Q  <= 8'hFF;
              R  <= A;
              DZ <= 1'b1;
            end
          end
        end
        c_RUN: begin
          r_partRem  <= w_remNext;
          r_quoShift <= w_quoNext;
          r_iterCnt  <= r_iterCnt + 3'd1;
          if (r_iterCnt == 3'd7) begin
            Q  <= w_quoNext;
            R  <= w_remNext;
            DZ <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div8_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_div8_seq
// Purpose  : Self-checking directed bench for div8_seq.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_div8_seq;

  logic       CK;
  logic       RSTn;
  logic       START;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Q;
  logic [7:0] R;
  logic       BUSY;
  logic       DONE;
  logic       DZ;

  int checks = 0;
  int errors = 0;

  div8_seq dut (
    .CK   (CK),
    .RSTn (RSTn),
    .START(START),
    .A    (A),
    .B    (B),
    .Q    (Q),
    .R    (R),
    .BUSY (BUSY),
    .DONE (DONE),
    .DZ   (DZ)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Issue one division from IDLE and wait (bounded) for DONE. lat counts
  // cycles from the accepting edge to the DONE cycle; 20 means timeout.
  // Returns with the DUT back in IDLE.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic dz, output int lat);
    @(negedge CK);
    A = a; B = b; START = 1'b1;
    @(posedge CK);
    #1;
    START = 1'b0;
    A = 8'hxx; B = 8'hxx;
    lat = 1;
    while (!DONE && lat < 20) begin
      @(posedge CK);
      #1;
      lat++;
    end
    q = Q; r = R; dz = DZ;
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset;
    RSTn = 1'b0; START = 1'b0; A = 8'd0; B = 8'd0;
    repeat (3) @(posedge CK);
    #1;
    checks++;
    if ({Q, R, DZ, BUSY, DONE} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got Q=%0d R=%0d DZ=%0b BUSY=%0b DONE=%0b, want all 0", Q, R, DZ, BUSY, DONE);
    end
    @(negedge CK);
    RSTn = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    int busyCycles;
    logic holdBad;
    @(negedge CK);
    A = 8'd100; B = 8'd7; START = 1'b1;
    @(posedge CK);
    #1;
    START = 1'b0;
    lat = 1; busyCycles = 0; holdBad = 1'b0;
    while (!DONE && lat < 20) begin
      if (BUSY) busyCycles++;
      if (Q !== 8'd0 || R !== 8'd0) holdBad = 1'b1;
      @(posedge CK);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL basic_latency: got %0d, want 9", lat);
    end
    checks++;
    if (holdBad !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: Q/R changed before FIN (got %0b, want 0)", holdBad);
    end
    checks++;
    if (Q !== 8'd14 || R !== 8'd2 || DZ !== 1'b0) begin
      errors++;
      $display("FAIL basic_100_7: got Q=%0d R=%0d DZ=%0b, want Q=14 R=2 DZ=0", Q, R, DZ);
    end
    if (BUSY) busyCycles++;
    @(posedge CK);
    #1;
    checks++;
    if (busyCycles !== 9 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: got busyCycles=%0d BUSY=%0b DONE=%0b, want 9 0 0", busyCycles, BUSY, DONE);
    end
  endtask

  task automatic test_vectors;
    logic [7:0] va [3] = '{8'd255, 8'd5,   8'd0};
    logic [7:0] vb [3] = '{8'd1,   8'd200, 8'd3};
    logic [7:0] eq [3] = '{8'd255, 8'd0,   8'd0};
    logic [7:0] er [3] = '{8'd0,   8'd5,   8'd0};
    logic [7:0] q, r;
    logic dz;
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_div(va[i], vb[i], q, r, dz, lat);
      checks++;
      if (q !== eq[i] || r !== er[i] || dz !== 1'b0 || lat !== 9) begin
        errors++;
        $display("FAIL vector_%0d_%0d: got Q=%0d R=%0d DZ=%0b lat=%0d, want Q=%0d R=%0d DZ=0 lat=9",
                 va[i], vb[i], q, r, dz, lat, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [7:0] q, r;
    logic dz;
    int lat;
    do_div(8'd42, 8'd0, q, r, dz, lat);
    checks++;
    if (q !== 8'hFF || r !== 8'd42 || dz !== 1'b1 || lat !== 1) begin
      errors++;
      $display("FAIL div_zero: got Q=%0h R=%0d DZ=%0b lat=%0d, want Q=ff R=42 DZ=1 lat=1", q, r, dz, lat);
    end
    do_div(8'd9, 8'd3, q, r, dz, lat);
    checks++;
    if (q !== 8'd3 || r !== 8'd0 || dz !== 1'b0 || lat !== 9) begin
      errors++;
      $display("FAIL after_div_zero: got Q=%0d R=%0d DZ=%0b lat=%0d, want Q=3 R=0 DZ=0 lat=9", q, r, dz, lat);
    end
  endtask

  task automatic test_back_to_back;
    int doneAt [$];
    int cyc;
    @(negedge CK);
    A = 8'd200; B = 8'd13; START = 1'b1;
    cyc = 0;
    repeat (45) begin
      @(posedge CK);
      #1;
      cyc++;
      if (DONE) begin
        doneAt.push_back(cyc);
        checks++;
        if (Q !== 8'd15 || R !== 8'd5 || DZ !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result: got Q=%0d R=%0d DZ=%0b, want Q=15 R=5 DZ=0", Q, R, DZ);
        end
      end
    end
    START = 1'b0;
    checks++;
    if (doneAt.size() !== 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d DONE pulses, want 4", doneAt.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (doneAt[i] !== 9 + 10 * i) begin
          errors++;
          $display("FAIL b2b_timing_%0d: DONE at cycle %0d, want %0d", i, doneAt[i], 9 + 10 * i);
        end
      end
    end
    cyc = 0;
    while (BUSY && cyc < 20) begin
      @(posedge CK);
      #1;
      cyc++;
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: BUSY=%0b after drain, want 0", BUSY);
    end
  endtask

  task automatic test_reset_midrun;
    logic [7:0] q, r;
    logic dz;
    int lat;
    logic sawDone;
    @(negedge CK);
    A = 8'd77; B = 8'd5; START = 1'b1;
    @(posedge CK);
    #1;
    START = 1'b0;
    repeat (4) @(posedge CK);
    @(negedge CK);
    RSTn = 1'b0;
    #1;
    checks++;
    if ({Q, R, DZ, BUSY, DONE} !== 19'd0) begin
      errors++;
      $display("FAIL midrun_reset: got Q=%0d R=%0d DZ=%0b BUSY=%0b DONE=%0b, want all 0", Q, R, DZ, BUSY, DONE);
    end
    sawDone = 1'b0;
    repeat (4) begin
      @(posedge CK);
      #1;
      if (DONE) sawDone = 1'b1;
    end
    @(negedge CK);
    RSTn = 1'b1;
    repeat (12) begin
      @(posedge CK);
      #1;
      if (DONE || BUSY) sawDone = 1'b1;
    end
    checks++;
    if (sawDone !== 1'b0) begin
      errors++;
      $display("FAIL midrun_no_done: got activity=%0b after reset, want 0", sawDone);
    end
    do_div(8'd77, 8'd5, q, r, dz, lat);
    checks++;
    if (q !== 8'd15 || r !== 8'd2 || dz !== 1'b0 || lat !== 9) begin
      errors++;
      $display("FAIL midrun_rerun: got Q=%0d R=%0d DZ=%0b lat=%0d, want Q=15 R=2 DZ=0 lat=9", q, r, dz, lat);
    end
  endtask

  task automatic test_sweep;
    logic [7:0] a, b, q, r;
    logic dz;
    int lat;
    int badCases;
    badCases = 0;
    for (int i = 0; i < 400; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      if (i < 4) begin
        a = (i[0]) ? 8'd255 : 8'd0;
        b = (i[1]) ? 8'd255 : 8'd1;
      end
      do_div(a, b, q, r, dz, lat);
      checks++;
      if (q !== a / b || r !== a % b || dz !== 1'b0 || lat !== 9 ||
          (16'(q) * 16'(b) + 16'(r)) !== 16'(a) || !(r < b)) begin
        errors++;
        badCases++;
        if (badCases <= 10)
          $display("FAIL sweep_%0d_%0d: got Q=%0d R=%0d DZ=%0b lat=%0d, want Q=%0d R=%0d DZ=0 lat=9",
                   a, b, q, r, dz, lat, a / b, a % b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_back_to_back();
    test_reset_midrun();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div8_seq.md
# div8_seq

Sequential 8-bit unsigned divider, the inverse of the team's shift-and-add multiplier. It computes quotient and remainder by restoring shift-and-subtract, one quotient bit per clock, MSB first. It sits beside the multiplier in the arithmetic unit, uses the same single clock, and takes its operands from the same 8-bit operand buses. A start/done handshake replaces the free-running counter scheme so the controller knows exactly when results are valid.

## Interface
- Parameters: none (width fixed at 8).
- CK  in  1  system clock; all state updates on the rising edge.
- RSTn  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- START  in  1  request a division; sampled only in IDLE.
- A  in  8  dividend, unsigned; captured on the accepting edge.
- B  in  8  divisor, unsigned; captured on the accepting edge.
- Q  out  8  quotient, registered; holds until the next accepted START completes.
- R  out  8  remainder, registered; same hold rule as Q.
- BUSY  out  1  high while a division is in progress.
- DONE  out  1  one-cycle pulse; Q/R/DZ are valid from this cycle onward.
- DZ  out  1  divide-by-zero flag for the last result; same hold rule as Q.

## Operation
- States: IDLE, RUN, FIN.
- IDLE, START=0: stay in IDLE.
- IDLE, START=1, B≠0: capture A into the shift register QS and B into DV. Clear the 9-bit partial remainder PR. Clear the 3-bit iteration counter CNT. Go to RUN.
- IDLE, START=1, B=0: go to FIN with the pending result Q=8'hFF, R=A, DZ=1. No iterations are performed.
- RUN, per edge:
  - T = {PR[7:0], QS[7]} (9 bits).
  - If T ≥ {1'b0,DV}: PR←T−DV and QS←{QS[6:0],1}.
  - Else: PR←T and QS←{QS[6:0],0}.
  - CNT←CNT+1.
  - Exit to FIN on the edge where CNT=7 (8 iterations total).
- FIN: the edge into FIN loads Q←QS and R←PR[7:0]. DZ is loaded 0, or 1 for the divide-by-zero path. FIN lasts one cycle, then the block returns to IDLE.
- Arithmetic invariants:
  - PR < DV after every iteration, so R < B always.
  - A = Q·B + R for every B≠0.
  - Q, R ≤ 255, so there is no overflow case.
- START in RUN or FIN is ignored. It is not queued; the requester must re-assert START in IDLE.
- A and B may change freely after the accepting edge.
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE.
  - Q=0, R=0, DZ=0, BUSY=0, DONE=0.
  - PR, QS, DV and CNT cleared.
  - An interrupted division produces no DONE.
- BUSY=1 in RUN and FIN, 0 in IDLE. DONE=1 only in FIN. Both are decoded from registered state, so they are glitch-free.

## Timing
- START high at accepting edge e0 (state IDLE), B≠0:
  - RUN spans the cycles after e0 through e8; iterations occur at edges e1..e8.
  - The edge e8 enters FIN and loads Q/R.
  - DONE is high for the cycle after e8; state is IDLE after e9.
  - Latency: 9 cycles from the accepting edge to DONE. Issue interval: 10 cycles.
- B=0: DONE is high the cycle after e0. Latency 1 cycle, issue interval 2 cycles.
- BUSY rises the cycle after e0 and falls with the edge that leaves FIN.
- Q/R/DZ hold their previous values until the edge that enters FIN.
- Reset deassertion: the first START is accepted on the first rising edge with RSTn=1.

## Test plan
- A=100, B=7, START pulse → DONE 9 cycles after accept; Q=14, R=2, DZ=0; BUSY high for exactly 9 cycles.
- A=255, B=1 → Q=255, R=0. Then A=5, B=200 → Q=0, R=5. Then A=0, B=3 → Q=0, R=0.
- A=42, B=0 → DONE 1 cycle after accept; Q=8'hFF, R=42, DZ=1. The next division A=9, B=3 then gives Q=3, R=0, DZ=0.
- START held high continuously with A=200, B=13 → Q=15, R=5 on each DONE; DONE pulses exactly every 10 cycles; no extra accepts while BUSY.
- Pull RSTn low 4 cycles into a run of A=77, B=5 → all outputs 0 immediately, with no DONE. After release, A=77, B=5 → Q=15, R=2.
- Random/exhaustive sweep of all A, and B in 1..255 → A = Q·B + R and R < B for every case; scoreboard against a reference model.
